// File: rtl/cnt_pkg.sv
// Shared definitions for the up/down interval counters: state encoding,
// default width and mode constants.
package cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cnt_state_t;

  localparam int unsigned CNT_WIDTH_DEF = 4;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_floor.sv
// Programmable down-counter / interval timer: loads a period, counts down on
// enabled cycles, flags borrow at zero, one-shot or periodic reload.
module cnt_floor
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] ceil,
  output logic [WIDTH-1:0] cnt,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  cnt_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_ceil_q, w_ceil_nxt;
  logic             w_tc;

  assign w_tc = (r_state == ST_RUN) && en && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ceil_q <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ceil_q <= w_ceil_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ceil_nxt  = r_ceil_q;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = ceil;
          w_ceil_nxt  = ceil;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        // stop outranks terminal count, which outranks the decrement
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_tc) begin
          if (mode == MODE_PERIODIC) begin
            w_cnt_nxt  = ceil;
            w_ceil_nxt = ceil;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else if (en) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign cnt  = r_cnt;
  assign bo   = w_tc;
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

  // The running count can never exceed the period it was loaded from.
  a_cnt_le_period: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_RUN) |-> (r_cnt <= r_ceil_q));

endmodule

// File: tb/tb_cnt_floor.sv
// Self-checking bench for cnt_floor: vector table plus hand-written sequences,
// expectations queued on drive and compared when the DUT responds.
module tb_cnt_floor;

  logic       clk;
  logic       rst_n;
  logic       en, start, stop, mode;
  logic [3:0] ceil;
  logic [3:0] cnt;
  logic       bo, busy, done;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       en;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] ceil;
    logic       bo;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    logic       bo;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  cnt_floor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .ceil  (ceil),
    .cnt   (cnt),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Entered at posedge+1: drive, check bo mid-cycle, clock, check registers.
  task automatic step(input logic i_en, input logic i_start, input logic i_stop,
                      input logic i_mode, input logic [3:0] i_ceil,
                      input logic e_bo, input logic [3:0] e_cnt,
                      input logic e_busy, input logic e_done);
    exp_t e;
    en = i_en; start = i_start; stop = i_stop; mode = i_mode; ceil = i_ceil;
    sb.push_back('{e_bo, e_cnt, e_busy, e_done});
    @(negedge clk);
    chk("bo", int'(bo), int'(sb[0].bo));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cnt", int'(cnt), int'(e.cnt));
    chk("busy", int'(busy), int'(e.busy));
    chk("done", int'(done), int'(e.done));
  endtask

  task automatic add(input logic i_en, input logic i_start, input logic i_stop,
                     input logic i_mode, input logic [3:0] i_ceil,
                     input logic e_bo, input logic [3:0] e_cnt,
                     input logic e_busy, input logic e_done);
    tbl.push_back('{i_en, i_start, i_stop, i_mode, i_ceil, e_bo, e_cnt, e_busy, e_done});
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;

    // en  st  sp  md  ceil  bo  cnt busy done
    // one-shot ceil=3 with enable gaps
    add(0, 1, 0, 0, 3,   0, 3, 1, 0);
    add(1, 0, 0, 0, 3,   0, 2, 1, 0);
    add(0, 0, 0, 0, 3,   0, 2, 1, 0);
    add(1, 0, 0, 0, 3,   0, 1, 1, 0);
    add(0, 0, 0, 0, 3,   0, 1, 1, 0);
    add(1, 0, 0, 0, 3,   0, 0, 1, 0);
    add(0, 0, 0, 0, 3,   0, 0, 1, 0);
    add(1, 0, 0, 0, 3,   1, 0, 0, 1);
    add(1, 0, 0, 0, 3,   0, 0, 0, 0);
    // stop at cnt=5, start in RUN ignored
    add(0, 1, 0, 1, 9,   0, 9, 1, 0);
    add(1, 0, 0, 1, 9,   0, 8, 1, 0);
    add(1, 0, 0, 1, 9,   0, 7, 1, 0);
    add(1, 0, 0, 1, 9,   0, 6, 1, 0);
    add(1, 0, 0, 1, 9,   0, 5, 1, 0);
    add(0, 1, 0, 1, 2,   0, 5, 1, 0);
    add(1, 0, 1, 1, 9,   0, 0, 0, 0);
    add(0, 0, 1, 1, 9,   0, 0, 0, 0);
    // stop at terminal count: bo visible, no done
    add(0, 1, 0, 0, 0,   0, 0, 1, 0);
    add(1, 0, 1, 0, 0,   1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 0, 0);
    // start accepted in DONE
    add(0, 1, 0, 0, 1,   0, 1, 1, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0);
    add(1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(1, 1, 0, 0, 2,   0, 2, 1, 0);
    add(0, 0, 1, 0, 2,   0, 0, 0, 0);
    // mode only matters at terminal count
    add(0, 1, 0, 1, 1,   0, 1, 1, 0);
    add(1, 0, 0, 0, 1,   0, 0, 1, 0);
    add(1, 0, 0, 1, 1,   1, 1, 1, 0);
    add(1, 0, 0, 1, 1,   0, 0, 1, 0);
    add(1, 0, 0, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 0, 1,   0, 0, 0, 0);

    // reset with en=1 and start toggling
    rst_n = 1'b0; en = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b1; ceil = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      #1;
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_bo", int'(bo), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_idle_busy", int'(busy), 0);

    foreach (tbl[i])
      step(tbl[i].en, tbl[i].start, tbl[i].stop, tbl[i].mode, tbl[i].ceil,
           tbl[i].bo, tbl[i].cnt, tbl[i].busy, tbl[i].done);

    // periodic ceil=12: two full periods, then down to cnt=8
    step(1, 1, 0, 1, 12, 0, 12, 1, 0);
    for (int j = 0; j < 30; j++)
      step(1, 0, 0, 1, 12, (j % 13) == 12, 4'(12 - ((j + 1) % 13)), 1, 0);
    // ceil 12->6 at cnt=8: current period finishes, then 7-cycle periods
    for (int k = 0; k < 9; k++)
      step(1, 0, 0, 1, 6, k == 8, (k < 8) ? 4'(7 - k) : 4'd6, 1, 0);
    for (int k = 0; k < 14; k++)
      step(1, 0, 0, 1, 6, (k % 7) == 6, 4'(6 - ((k + 1) % 7)), 1, 0);
    step(0, 0, 1, 1, 6, 0, 0, 0, 0);

    // ceil=0 periodic: bo every enabled cycle
    step(1, 1, 0, 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, 1, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);

    // asynchronous reset mid-count
    step(0, 1, 0, 0, 5, 0, 5, 1, 0);
    step(1, 0, 0, 0, 5, 0, 4, 1, 0);
    step(1, 0, 0, 0, 5, 0, 3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", int'(cnt), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_bo", int'(bo), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_cnt", int'(cnt), 0);
    chk("arst_hold_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 2, 0, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_floor.md
# cnt_floor

Programmable down-counter and interval timer: the counterpart of the up-counting ceiling counter. It loads a period from `ceil`, counts down to zero on enabled cycles, and flags the borrow. It runs one-shot or periodic, with start/stop control and busy/done status. It sits beside the up-counter in the timing/demo datapath as its event-generating partner: tick dividers, timeouts and periodic strobes.

## Interface
- `WIDTH`, default 4: counter and ceiling width in bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: count enable; the counter decrements only in cycles with `en`=1.
- `start` input 1: begin a count; accepted only in IDLE or DONE.
- `stop` input 1: abort the count; returns to IDLE.
- `mode` input 1: 0 = one-shot, 1 = periodic reload.
- `ceil` input WIDTH: reload value; sampled at start and at every reload.
- `cnt` output WIDTH: current count.
- `bo` output 1: borrow out; combinational, equals RUN & `en` & (`cnt`==0).
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse in DONE (one-shot completion only).

## Operation
- **States:** IDLE, RUN, DONE. Internal register `ceil_q` holds the active period value.
- **IDLE:**
  - `cnt`=0.
  - `start`=1 → `cnt`<=`ceil`, `ceil_q`<=`ceil`, go to RUN.
- **RUN, `en`=1, `cnt`!=0:** `cnt`<=`cnt`-1.
- **RUN, `en`=1, `cnt`==0:** `bo`=1 this cycle, then:
  - periodic → `cnt`<=`ceil`, `ceil_q`<=`ceil`, stay in RUN;
  - one-shot → go to DONE with `cnt` held at 0.
- **RUN, `en`=0:** hold `cnt`; `bo`=0.
- **DONE:** lasts exactly one cycle.
  - `start`=1 → reload and go to RUN, as from IDLE.
  - otherwise → IDLE.
- **Period:** `ceil`+1 enabled cycles per count. `ceil`=0 gives `bo` on every enabled cycle in periodic mode.
- **Priority in RUN:** `stop` > terminal-count/reload > decrement.
  - `stop` → IDLE, `cnt`<=0, no `bo` reload, no `done`.
  - `bo` is still combinationally visible in the `stop` cycle if `en` & `cnt`==0.
- **Ignored inputs:**
  - `start` in RUN is ignored; there is no restart.
  - `stop` in IDLE/DONE is ignored.
- **Ceiling changes:** a `ceil` change mid-period does not affect the current period; it takes effect at the next reload.
- **Arithmetic:** unsigned WIDTH-bit; the decrement never wraps because zero is handled as terminal.
- **Mode changes:** `mode` is sampled only at terminal count.

## Timing
- **Reset (async assert, sync-clean deassert on first edge):** state=IDLE, `cnt`=0, `ceil_q`=0, `bo`=0, `busy`=0, `done`=0.
- **Reset mid-count:** aborts immediately; no `done` or `bo` afterwards.
- **Start latency:** `start` sampled at edge k → `busy`=1 and `cnt`=`ceil` visible after edge k.
- **Terminal-count latency:** first `bo` occurs `ceil` enabled edges after start. `bo` is high during the cycle before the reload/DONE edge.
- **One-shot completion:** `done` is high for the one cycle after the terminal edge; `busy` drops on that same edge.
- **Stop latency:** `stop` sampled at edge k → `busy`=0 and `cnt`=0 after edge k.
- **Outputs:** `cnt`, `busy` and `done` are registered/state-decoded; `bo` is the only combinational output.

## Structure
- **Shared package/header `cnt_pkg`:** state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default `WIDTH`, mode constants (`MODE_ONESHOT`, `MODE_PERIODIC`). The up-counter uses the same header.
- **Sub-modules:** none required. A single module holds the FSM plus the count/`ceil_q` registers.

## Test plan
- **Reset:**
  - Stimulus: `rst_n`=0 with `en`=1 and `start` toggling.
  - Required: `cnt`=0 and `busy`/`done`/`bo`=0 throughout; IDLE after release.
- **Periodic count:**
  - Stimulus: `ceil`=12, `mode`=1, `en`=1, `start` pulse.
  - Required: `cnt` runs 12,11,…,0,12; `bo` high exactly every 13th cycle; `done` never asserts.
- **One-shot with enable gaps:**
  - Stimulus: `ceil`=3, `mode`=0, `en` toggling 1/0.
  - Required: 4 enabled cycles to `bo`; `cnt` holds during `en`=0; `done` pulses once; IDLE next.
- **Ceiling change mid-period:**
  - Stimulus: `ceil` changed 12→6 while `cnt`=8.
  - Required: counts down to 0; reloads to 6; next period is 7 cycles.
- **Stop and start conflicts:**
  - Stimulus: `stop` asserted at `cnt`=5; then `start` in RUN.
  - Required: `stop` gives `cnt`=0 and `busy`=0 the next cycle with no `done`; `start` in RUN leaves `cnt` unchanged.
- **`ceil`=0 periodic:**
  - Stimulus: `ceil`=0, `mode`=1, `en`=1.
  - Required: `bo` high every enabled cycle and `cnt` stays 0; `en`=0 forces `bo`=0.
